// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, constants and hex segment table for the seven-segment scanner
package seven_seg_pkg;

  typedef enum logic {S_OFF, S_SCAN} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 (F) is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational nibble to active-low seven-segment pattern
module seg7_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 8-digit multiplexed display scanner with frame-synchronous double-buffered writes
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV_BITS = 3,
  parameter int NUM_DIGITS   = 8
)(
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    WrEn,
  input  logic [4*NUM_DIGITS-1:0] WrData,
  output logic                    WrReady,
  input  logic                    LzBlank,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  output logic [NUM_DIGITS-1:0]   SevenSegAn,
  output logic [6:0]              SevenSegCat,
  output logic                    FrameDone
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CLK_DIV_BITS-1:0] presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_W-1:0]       disp_q;
  logic [DATA_W-1:0]       pend_data_q;
  logic                    pend_valid_q;
  logic                    wr_ready_q;
  logic                    frame_done_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              cat_q;

  logic [DATA_W-1:0]       disp_shift;
  logic [6:0]              digit_seg;
  logic [NUM_DIGITS-1:0]   digit_an;
  logic                    digit_blank;
  logic                    tick;
  logic                    wr_accept;

  // Shifting the current digit to the bottom gives both its nibble and the leading-zero test.
  assign disp_shift  = disp_q >> {idx_q, 2'b00};
  assign digit_blank = BlankMask[idx_q] | (LzBlank & (idx_q != '0) & (disp_shift == '0));
  assign digit_an    = ~(NUM_DIGITS'(1) << idx_q);
  assign tick        = (presc_q == '1);
  assign wr_accept   = WrEn & wr_ready_q;

  seg7_hex_decoder u_hex_decoder (
    .nibble_i (disp_shift[3:0]),
    .seg_o    (digit_seg)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (Enable)  state_d = S_SCAN;
      S_SCAN:  if (!Enable) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_OFF;
      presc_q      <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
      an_q         <= NUM_DIGITS'(AN_OFF);
      cat_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      frame_done_q <= 1'b0;

      if (state_q == S_SCAN && Enable) begin
        an_q  <= digit_blank ? NUM_DIGITS'(AN_OFF) : digit_an;
        cat_q <= digit_blank ? SEG_BLANK : digit_seg;
      end else begin
        an_q  <= NUM_DIGITS'(AN_OFF);
        cat_q <= SEG_BLANK;
      end

      case (state_q)
        S_OFF: begin
          presc_q <= '0;
          idx_q   <= '0;
          // No scanning means no tearing risk, so a pending value is shown right away.
          if (pend_valid_q) begin
            disp_q       <= pend_data_q;
            pend_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
          end
        end
        S_SCAN: begin
          if (!Enable) begin
            presc_q <= '0;
            idx_q   <= '0;
          end else begin
            presc_q <= presc_q + CLK_DIV_BITS'(1);
            if (tick) begin
              if (idx_q == LAST_IDX) begin
                idx_q        <= '0;
                frame_done_q <= 1'b1;
                if (pend_valid_q) begin
                  disp_q       <= pend_data_q;
                  pend_valid_q <= 1'b0;
                  wr_ready_q   <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
        end
        default: begin
          presc_q <= '0;
          idx_q   <= '0;
        end
      endcase

      // Apply and accept are exclusive: accept needs wr_ready_q, apply needs pend_valid_q.
      if (wr_accept) begin
        pend_data_q  <= WrData;
        pend_valid_q <= 1'b1;
        wr_ready_q   <= 1'b0;
      end
    end
  end

  assign WrReady     = wr_ready_q;
  assign FrameDone   = frame_done_q;
  assign SevenSegAn  = an_q;
  assign SevenSegCat = cat_q;

endmodule
